// File: rtl/order_arbiter.sv
`default_nettype none
// ============================================================================
// order_arbiter: round-robin order arbiter, registered output, token-bucket throttle
// Revision 1.0
// ============================================================================
module order_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int ORDER_WIDTH   = 128,
  parameter int TOKEN_MAX     = 16,
  parameter int REFILL_PERIOD = 1000
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ORDER_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           out_valid,
  output logic [ORDER_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]     out_src,
  input  logic                           out_ready,
  input  logic                           throttle_en,
  output logic [7:0]                     tokens,
  output logic [31:0]                    throttled_cnt
);

  localparam int                SRC_W       = $clog2(NUM_REQ);
  localparam int                CNT_W       = $clog2(REFILL_PERIOD);
  localparam logic [7:0]        TOKEN_FULL  = 8'(TOKEN_MAX);
  localparam logic [CNT_W-1:0]  REFILL_LAST = CNT_W'(REFILL_PERIOD - 1);
  localparam logic [SRC_W-1:0]  SRC_LAST    = SRC_W'(NUM_REQ - 1);
  localparam logic [SRC_W:0]    SRC_COUNT   = (SRC_W + 1)'(NUM_REQ);

  typedef enum logic [0:0] {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                 state, state_next;
  logic [SRC_W-1:0]       rr_ptr;
  logic [SRC_W-1:0]       win_idx;
  logic [ORDER_WIDTH-1:0] win_data;
  logic [NUM_REQ-1:0]     rot_req;
  logic [SRC_W:0]         win_sum;
  logic [CNT_W-1:0]       refill_cnt;
  logic                   win_found;
  logic                   stage_free;
  logic                   any_req;
  logic                   token_ok;
  logic                   grant;
  logic                   refill_evt;
  logic                   consume;

  // Rotate so that bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_sum   = '0;
    rot_req   = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && rot_req[k]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, rr_ptr} + (SRC_W + 1)'(k);
        if (win_sum >= SRC_COUNT) begin
          win_sum = win_sum - SRC_COUNT;
        end
        win_idx = win_sum[SRC_W-1:0];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == SRC_W'(k)) begin
        win_data = req_data[k*ORDER_WIDTH +: ORDER_WIDTH];
      end
    end
  end

  assign stage_free = (state == EMPTY) || out_ready;
  assign any_req    = |req_valid;
  assign token_ok   = !throttle_en || (tokens != 8'd0);
  assign grant      = reset_n && stage_free && any_req && token_ok;
  assign refill_evt = (refill_cnt == REFILL_LAST);
  assign consume    = grant && throttle_en;
  assign out_valid  = (state == FULL);

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (grant) state_next = FULL;
      FULL:    if (!grant && out_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data <= '0;
      out_src  <= '0;
      rr_ptr   <= '0;
    end else if (grant) begin
      out_data <= win_data;
      out_src  <= win_idx;
      rr_ptr   <= (win_idx == SRC_LAST) ? '0 : win_idx + 1'b1;
    end
  end

  // A refill and a throttled grant in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      refill_cnt    <= '0;
      tokens        <= TOKEN_FULL;
      throttled_cnt <= '0;
    end else begin
      refill_cnt <= refill_evt ? '0 : refill_cnt + 1'b1;
      if (refill_evt && !consume) begin
        if (tokens != TOKEN_FULL) begin
          tokens <= tokens + 8'd1;
        end
      end else if (consume && !refill_evt) begin
        tokens <= tokens - 8'd1;
      end
      if (throttle_en && (tokens == 8'd0) && stage_free && any_req &&
          (throttled_cnt != 32'hFFFF_FFFF)) begin
        throttled_cnt <= throttled_cnt + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_order_arbiter.sv
`default_nettype none
// ============================================================================
// tb_order_arbiter: directed scenarios plus randomized traffic against a cycle model
// Revision 1.0
// ============================================================================
module tb_order_arbiter;

  localparam int N      = 4;
  localparam int OW     = 128;
  localparam int TMAX   = 16;
  localparam int REFILL = 40;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*OW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            out_valid;
  logic [OW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  logic            throttle_en;
  logic [7:0]      tokens;
  logic [31:0]     throttled_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_full;
  logic [OW-1:0] m_data;
  int          m_src, m_ptr, m_refill, m_tokens;
  longint      m_thr;
  logic [N-1:0] obs_ready, exp_ready;

  order_arbiter #(
    .NUM_REQ(N), .ORDER_WIDTH(OW), .TOKEN_MAX(TMAX), .REFILL_PERIOD(REFILL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .throttle_en(throttle_en),
    .tokens(tokens), .throttled_cnt(throttled_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_full = 0; m_data = '0; m_src = 0; m_ptr = 0;
    m_refill = 0; m_tokens = TMAX; m_thr = 0;
  endtask

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if ((req_valid & (N'(1) << idx)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic bit model_grant();
    return (!m_full || out_ready) && (req_valid != '0) && (!throttle_en || m_tokens > 0);
  endfunction

  function automatic logic [N-1:0] model_ready();
    int w = model_winner();
    if (model_grant() && w >= 0) return N'(1) << w;
    return '0;
  endfunction

  task automatic model_edge();
    bit free = !m_full || out_ready;
    bit any  = (req_valid != '0);
    bit g    = model_grant();
    bit refill = (m_refill == REFILL - 1);
    bit cons = g && throttle_en;
    int w    = model_winner();
    if (throttle_en && m_tokens == 0 && free && any && m_thr < 64'hFFFF_FFFF) m_thr++;
    if (refill && !cons) m_tokens = (m_tokens + 1 > TMAX) ? TMAX : m_tokens + 1;
    else if (cons && !refill) m_tokens--;
    m_refill = (m_refill + 1) % REFILL;
    if (g) begin
      m_full = 1; m_data = req_data[w*OW +: OW]; m_src = w; m_ptr = (w + 1) % N;
    end else if (out_ready) begin
      m_full = 0;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic [N-1:0] v, input logic ordy, input logic thr);
    req_valid = v; out_ready = ordy; throttle_en = thr;
    for (int i = 0; i < N; i++) req_data[i*OW +: OW] = {$urandom, $urandom, $urandom, $urandom};
    #1;
    obs_ready = req_ready;
    exp_ready = model_ready();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '1; out_ready = 1'b1; throttle_en = 1'b0; req_data = '1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_cmp++; if (out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d want 0", out_src); end
    n_cmp++; if (tokens !== 8'(TMAX)) begin n_fail++; $display("FAIL reset_tokens: got %0d want %0d", tokens, TMAX); end
    n_cmp++; if (throttled_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_thr: got %0d want 0", throttled_cnt); end
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      n_cmp++; if (obs_ready !== N'(1) << (k % 4)) begin n_fail++; $display("FAIL rr_ready cyc %0d: got %b want %b", k, obs_ready, N'(1) << (k % 4)); end
      n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_src cyc %0d: got v=%b src=%0d want v=1 src=%0d", k, out_valid, out_src, k % 4); end
      n_cmp++; if (out_data !== m_data) begin n_fail++; $display("FAIL rr_data cyc %0d: got %h want %h", k, out_data, m_data); end
    end
  endtask

  task automatic test_backpressure();
    logic [OW-1:0] held;
    cycle(4'b0000, 1'b1, 1'b0);
    cycle(4'b0100, 1'b0, 1'b0);
    held = out_data;
    n_cmp++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_first_ready: got %b want 0100", obs_ready); end
    n_cmp++; if (held !== m_data) begin n_fail++; $display("FAIL bp_first_data: got %h want %h", held, m_data); end
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0100, 1'b0, 1'b0);
      n_cmp++; if (obs_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_ready cyc %0d: got %b want 0000", k, obs_ready); end
      n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd2 || out_data !== held) begin
        n_fail++; $display("FAIL bp_hold cyc %0d: got v=%b src=%0d data=%h want v=1 src=2 data=%h", k, out_valid, out_src, out_data, held);
      end
    end
    cycle(4'b0100, 1'b1, 1'b0);
    n_cmp++; if (obs_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0100", obs_ready); end
    n_cmp++; if (out_data !== m_data || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_release_data: got %h want %h", out_data, m_data); end
    cycle(4'b0000, 1'b1, 1'b0);
  endtask

  task automatic test_throttle();
    int grants = 0;
    apply_reset();
    for (int c = 0; c < REFILL; c++) begin
      cycle(4'b1111, 1'b1, 1'b1);
      if (obs_ready != '0) grants++;
      n_cmp++; if (obs_ready !== exp_ready || tokens !== 8'(m_tokens) || throttled_cnt !== 32'(m_thr)) begin
        n_fail++; $display("FAIL thr_model cyc %0d: got rdy=%b tok=%0d thr=%0d want rdy=%b tok=%0d thr=%0d",
                           c, obs_ready, tokens, throttled_cnt, exp_ready, m_tokens, m_thr);
      end
      if (c == TMAX - 1) begin
        n_cmp++; if (tokens !== 8'd0) begin n_fail++; $display("FAIL thr_drained: got %0d want 0", tokens); end
      end
    end
    n_cmp++; if (grants != TMAX) begin n_fail++; $display("FAIL thr_grants: got %0d want %0d", grants, TMAX); end
    n_cmp++; if (throttled_cnt !== 32'(REFILL - TMAX)) begin n_fail++; $display("FAIL thr_count: got %0d want %0d", throttled_cnt, REFILL - TMAX); end
    n_cmp++; if (tokens !== 8'd1) begin n_fail++; $display("FAIL thr_refilled: got %0d want 1", tokens); end
    cycle(4'b1111, 1'b1, 1'b1);
    n_cmp++; if (obs_ready === '0 || tokens !== 8'd0) begin n_fail++; $display("FAIL thr_after_refill: got rdy=%b tok=%0d want grant tok=0", obs_ready, tokens); end
    // Unthrottled grants leave the empty bucket alone.
    for (int c = 0; c < 10; c++) begin
      cycle(4'b1111, 1'b1, 1'b0);
      n_cmp++; if (obs_ready === '0 || tokens !== 8'd0) begin n_fail++; $display("FAIL unthr cyc %0d: got rdy=%b tok=%0d want grant tok=0", c, obs_ready, tokens); end
    end
  endtask

  task automatic test_idle_refill();
    apply_reset();
    for (int c = 0; c < 2 * REFILL + 5; c++) cycle(4'b0000, 1'b1, 1'b1);
    n_cmp++; if (tokens !== 8'(TMAX) || throttled_cnt !== 32'd0) begin n_fail++; $display("FAIL idle_refill: got tok=%0d thr=%0d want tok=%0d thr=0", tokens, throttled_cnt, TMAX); end
  endtask

  task automatic test_reset_mid();
    cycle(4'b0001, 1'b0, 1'b1);
    cycle(4'b0001, 1'b0, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || req_ready !== '0) begin n_fail++; $display("FAIL async_reset: got v=%b rdy=%b want v=0 rdy=0000", out_valid, req_ready); end
    @(negedge clk);
    n_cmp++; if (tokens !== 8'(TMAX) || out_data !== '0) begin n_fail++; $display("FAIL mid_reset_state: got tok=%0d data=%h want tok=%0d data=0", tokens, out_data, TMAX); end
    reset_n = 1'b1;
    model_reset();
    cycle(4'b1010, 1'b1, 1'b0);
    n_cmp++; if (obs_ready !== 4'b0010 || out_src !== 2'd1) begin n_fail++; $display("FAIL post_reset_grant: got rdy=%b src=%0d want rdy=0010 src=1", obs_ready, out_src); end
  endtask

  task automatic test_rr_wrap();
    apply_reset();
    cycle(4'b0001, 1'b1, 1'b0);
    cycle(4'b1000, 1'b1, 1'b0);
    n_cmp++; if (obs_ready !== 4'b1000 || out_src !== 2'd3) begin n_fail++; $display("FAIL wrap_grant3: got rdy=%b src=%0d want rdy=1000 src=3", obs_ready, out_src); end
    cycle(4'b1111, 1'b1, 1'b0);
    n_cmp++; if (obs_ready !== 4'b0001 || out_src !== 2'd0) begin n_fail++; $display("FAIL wrap_ptr0: got rdy=%b src=%0d want rdy=0001 src=0", obs_ready, out_src); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      cycle(N'($urandom), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
      n_cmp++;
      if (obs_ready !== exp_ready || out_valid !== m_full || out_data !== m_data ||
          out_src !== 2'(m_src) || tokens !== 8'(m_tokens) || throttled_cnt !== 32'(m_thr)) begin
        n_fail++;
        $display("FAIL random cyc %0d: got rdy=%b v=%b src=%0d tok=%0d thr=%0d want rdy=%b v=%b src=%0d tok=%0d thr=%0d",
                 c, obs_ready, out_valid, out_src, tokens, throttled_cnt,
                 exp_ready, m_full, m_src, m_tokens, m_thr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_throttle();
    test_idle_refill();
    test_reset_mid();
    test_rr_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
